// File: rtl/ibex_mul_seq.sv
// Sequential radix-2 shift-add multiplier (MUL/MULH/MULHSU/MULHU) using the ALU adder.
// Optional macro IBEX_MUL_SEQ_ZERO_SKIP_EN: zero operand bypasses straight to DONE.
module ibex_mul_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        abort_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        alu_en_o,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    input  logic [33:0] alu_adder_ext_i
);

    typedef enum logic [2:0] {
        IDLE, ABS_A, ABS_B, MUL, NEG_LO, NEG_HI, DONE
    } state_t;

    state_t      state, state_d;
    logic [1:0]  op, op_d;
    logic [31:0] a, a_d, b, b_d, hi, hi_d, result;
    logic [4:0]  cnt, cnt_d;
    logic        c, c_d, nb, nb_d, neg, neg_d;
    logic [31:0] x, y, sum;
    logic        cin, carry, en;
    logic        na_in, nb_in;
    logic        unused_ext;

    assign sum        = alu_adder_ext_i[32:1];
    assign carry      = alu_adder_ext_i[33];
    assign unused_ext = alu_adder_ext_i[0];

    assign na_in = (op_i == 2'd1 || op_i == 2'd2) && op_a_i[31];
    assign nb_in = (op_i == 2'd1) && op_b_i[31];

    always_comb begin
        state_d = state;
        op_d    = op;
        a_d     = a;
        b_d     = b;
        hi_d    = hi;
        cnt_d   = cnt;
        c_d     = c;
        nb_d    = nb;
        neg_d   = neg;
        en      = 1'b0;
        x       = '0;
        y       = '0;
        cin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_i) begin
                    op_d  = op_i;
                    a_d   = op_a_i;
                    b_d   = op_b_i;
                    hi_d  = '0;
                    cnt_d = '0;
                    nb_d  = nb_in;
                    neg_d = na_in ^ nb_in;
                    state_d = na_in ? ABS_A : (nb_in ? ABS_B : MUL);
`ifdef IBEX_MUL_SEQ_ZERO_SKIP_EN
                    if (op_a_i == '0 || op_b_i == '0) begin
                        b_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            ABS_A: begin
                en      = 1'b1;
                y       = ~a;
                cin     = 1'b1;
                a_d     = sum;
                state_d = nb ? ABS_B : MUL;
            end
            ABS_B: begin
                en      = 1'b1;
                y       = ~b;
                cin     = 1'b1;
                b_d     = sum;
                state_d = MUL;
            end
            MUL: begin
                en    = 1'b1;
                x     = hi;
                y     = b[0] ? a : '0;
                // low product bits shift into B as the multiplier bits drain out
                {hi_d, b_d} = {carry, sum, b[31:1]};
                cnt_d = cnt + 5'd1;
                if (cnt == 5'd31) state_d = neg ? NEG_LO : DONE;
            end
            NEG_LO: begin
                en      = 1'b1;
                y       = ~b;
                cin     = 1'b1;
                b_d     = sum;
                c_d     = carry;
                state_d = NEG_HI;
            end
            NEG_HI: begin
                en      = 1'b1;
                y       = ~hi;
                cin     = c;
                hi_d    = sum;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i && state != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            op     <= '0;
            a      <= '0;
            b      <= '0;
            hi     <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            nb     <= 1'b0;
            neg    <= 1'b0;
            result <= '0;
        end else begin
            state <= state_d;
            op    <= op_d;
            a     <= a_d;
            b     <= b_d;
            hi    <= hi_d;
            cnt   <= cnt_d;
            c     <= c_d;
            nb    <= nb_d;
            neg   <= neg_d;
            if (state_d == DONE) result <= (op_d == 2'd0) ? b_d : hi_d;
        end
    end

    assign ready_o         = (state == IDLE);
    assign valid_o         = (state == DONE);
    assign result_o        = result;
    assign alu_en_o        = en;
    assign alu_operand_a_o = {x, cin};
    assign alu_operand_b_o = {y, cin};

endmodule

// File: tb/tb_ibex_mul_seq.sv
// Self-checking bench for ibex_mul_seq: vector table, random ops, abort and reset cases.
module tb_ibex_mul_seq;

    logic        clk, rst, req, abort;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        ready, valid, alu_en;
    logic [31:0] result;
    logic [32:0] opa, opb;
    logic [33:0] ext;

    int n_cmp = 0;
    int n_bad = 0;

    ibex_mul_seq dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op),
        .op_a_i(a), .op_b_i(b), .abort_i(abort),
        .ready_o(ready), .valid_o(valid), .result_o(result),
        .alu_en_o(alu_en), .alu_operand_a_o(opa),
        .alu_operand_b_o(opb), .alu_adder_ext_i(ext)
    );

    // ALU adder as seen by the multdiv port
    assign ext = {1'b0, opa} + {1'b0, opb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] ex, ey, p;
        logic sa, sb;
        sa = (o == 2'd1) || (o == 2'd2);
        sb = (o == 2'd1);
        ex = sa ? {{32{x[31]}}, x} : {32'b0, x};
        ey = sb ? {{32{y[31]}}, y} : {32'b0, y};
        p  = ex * ey;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_lat(input logic [1:0] o,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
        int na, nb;
`ifdef IBEX_MUL_SEQ_ZERO_SKIP_EN
        if (x == 0 || y == 0) return 1;
`endif
        na = ((o == 2'd1 || o == 2'd2) && x[31]) ? 1 : 0;
        nb = (o == 2'd1 && y[31]) ? 1 : 0;
        return 33 + na + nb + 2 * (na ^ nb);
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output logic [31:0] res,
                          output int lat, output bit en_seen);
        @(negedge clk);
        req = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        en_seen = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (alu_en) en_seen = 1'b1;
            if (valid) begin
                lat = j;
                break;
            end
        end
        res = result;
    endtask

    task automatic do_vec(input string name, input vec_t v);
        logic [31:0] res;
        int lat;
        bit en_seen;
        run_op(v.op, v.a, v.b, res, lat, en_seen);
        check({name, " result"}, res, v.exp);
        check({name, " latency"}, lat, v.lat);
        @(negedge clk);
        check({name, " valid_one_cycle"}, {valid, ready}, 2'b01);
        check({name, " result_held"}, result, v.exp);
    endtask

    vec_t tbl[10];

    initial begin
        logic [31:0] res, prev;
        int lat;
        bit en_seen, vseen;
        vec_t v;

        tbl[0] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        tbl[1] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
        tbl[2] = '{2'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 36};
        tbl[3] = '{2'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 33};
        tbl[4] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 35};
        tbl[5] = '{2'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 36};
        tbl[6] = '{2'd0, 32'h00000007, 32'h00000006, 32'h0000002A, 33};
        tbl[7] = '{2'd1, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF, 36};
        tbl[8] = '{2'd2, 32'h00000005, 32'hFFFFFFFF, 32'h00000004, 33};
`ifdef IBEX_MUL_SEQ_ZERO_SKIP_EN
        tbl[9] = '{2'd0, 32'h00000000, 32'h00001234, 32'h00000000, 1};
`else
        tbl[9] = '{2'd0, 32'h00000000, 32'h00001234, 32'h00000000, 33};
`endif

        rst = 1'b1; req = 1'b0; abort = 1'b0;
        op = '0; a = '0; b = '0;
        #12;
        check("reset ready/valid/en", {ready, valid, alu_en}, 3'b100);
        check("reset result", result, 0);
        check("reset operands", {opa, opb}, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) do_vec($sformatf("vec%0d", i), tbl[i]);

        run_op(2'd0, 32'h0, 32'h1234, res, lat, en_seen);
`ifdef IBEX_MUL_SEQ_ZERO_SKIP_EN
        check("zero_skip alu_en", en_seen, 1'b0);
`else
        check("zero_path alu_en", en_seen, 1'b1);
`endif
        check("zero_path result", res, 0);

        for (int k = 0; k < 40; k++) begin
            v.op = 2'($urandom_range(0, 3));
            v.a  = $urandom;
            v.b  = $urandom;
            if (k % 8 == 3) v.a = 32'h80000000;
            if (k % 8 == 5) v.b = 32'h0;
            if (k % 8 == 6) v.b = 32'hFFFFFFFF;
            v.exp = ref_mul(v.op, v.a, v.b);
            v.lat = ref_lat(v.op, v.a, v.b);
            do_vec($sformatf("rand%0d", k), v);
        end

        // abort at MUL cnt=10
        prev = result;
        @(negedge clk);
        req = 1'b1; op = 2'd0; a = 32'h12345678; b = 32'h9ABCDEF1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (11) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort ready", ready, 1'b1);
        check("abort alu_en", alu_en, 1'b0);
        check("abort result_kept", result, prev);
        vseen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid) vseen = 1'b1;
        end
        check("abort no_valid", vseen, 1'b0);
        do_vec("after_abort", tbl[6]);

        // async reset mid-MUL
        @(negedge clk);
        req = 1'b1; op = 2'd3; a = 32'hDEADBEEF; b = 32'hCAFEF00D;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (15) @(negedge clk);
        check("pre_reset busy", {ready, alu_en}, 2'b01);
        #1 rst = 1'b1;
        #1;
        check("async_reset ready/valid/en", {ready, valid, alu_en}, 3'b100);
        check("async_reset result", result, 0);
        check("async_reset operands", {opa, opb}, 0);
        @(negedge clk);
        rst = 1'b0;
        do_vec("after_reset", tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
